// File: rtl/core_bus_arbiter_pkg.sv
// bus_pkg: shared bus types, transfer sizes and arbiter state encoding
package bus_pkg;
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mbus_req_t;
  typedef struct packed {
    logic        ready;
    logic [63:0] data;
  } mbus_resp_t;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
endpackage

// File: rtl/core_bus_arbiter_if.sv
// core_bus_arbiter_if: fetch, data and downstream bus bundle shared by core, arbiter and memory
interface core_bus_arbiter_if;
  import bus_pkg::*;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  mbus_req_t  mreq;
  mbus_resp_t mresp;
  modport slave  (input ireq, dreq, mresp, output iresp, dresp, mreq);
  modport master (output ireq, dreq, mresp, input iresp, dresp, mreq);
endinterface

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: single-beat memory port sharing with dbus priority and bounded fetch starvation
module core_bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic               clk,
  input  logic               resetn,
  core_bus_arbiter_if.slave  bus
);
  localparam logic [3:0] MAX = 4'(MAX_D_STREAK);
  arb_state_t  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  mbus_req_t   req_q, req_d;
  logic        owner_q, owner_d;
  logic [63:0] rdata_q, rdata_d;
  logic        gnt_d, gnt_i, busy;
  assign busy  = state_q == BUSY_I || state_q == BUSY_D;
  assign gnt_d = state_q == IDLE && bus.dreq.valid && (!bus.ireq.valid || streak_q < MAX);
  assign gnt_i = state_q == IDLE && !gnt_d && bus.ireq.valid;
  // state register; reset drops any in-flight beat at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end
  // latched request, owner (1 = dbus), streak and response data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_q <= '0;
      req_q    <= '0;
      owner_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      streak_q <= streak_d;
      req_q    <= req_d;
      owner_q  <= owner_d;
      rdata_q  <= rdata_d;
    end
  end
  // next state: arbitrate in IDLE, wait for ready in BUSY, one RESP cycle
  always_comb begin
    state_d = state_q == IDLE ? (gnt_d ? BUSY_D : gnt_i ? BUSY_I : IDLE) :
              state_q == RESP ? IDLE :
              bus.mresp.ready ? RESP : state_q;
  end
  // datapath next values; the latched request only changes on a grant
  always_comb begin
    req_d    = req_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    rdata_d  = busy && bus.mresp.ready ? bus.mresp.data : rdata_q;
    if (gnt_d) begin
      req_d.valid    = 1'b1;
      req_d.is_write = |bus.dreq.strobe;
      req_d.size     = bus.dreq.size;
      req_d.addr     = bus.dreq.addr;
      req_d.strobe   = bus.dreq.strobe;
      req_d.data     = bus.dreq.data;
      owner_d        = 1'b1;
      streak_d       = !bus.ireq.valid ? 4'd0 : streak_q < MAX ? streak_q + 4'd1 : MAX;
    end else if (gnt_i) begin
      req_d      = '0;
      req_d.valid = 1'b1;
      req_d.size = MSIZE4;
      req_d.addr = bus.ireq.addr;
      owner_d    = 1'b0;
      streak_d   = '0;
    end
  end
  // outputs from registers; delivery only if the owner still presents the same request
  always_comb begin
    bus.mreq  = busy ? req_q : '0;
    bus.iresp = state_q == RESP && !owner_q && bus.ireq.valid && bus.ireq.addr == req_q.addr
                ? '{addr_ok: 1'b1, data_ok: 1'b1, data: rdata_q} : '0;
    bus.dresp = state_q == RESP && owner_q && bus.dreq.valid && bus.dreq.addr == req_q.addr &&
                bus.dreq.strobe == req_q.strobe
                ? '{addr_ok: 1'b1, data_ok: 1'b1, data: rdata_q} : '0;
  end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_core_bus_arbiter;
  import bus_pkg::*;
  localparam int MAXS = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  core_bus_arbiter_if bus();
  core_bus_arbiter #(.MAX_D_STREAK(MAXS)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  // model: one outstanding transaction, either waiting downstream or being answered
  bit          m_busy, m_resp, m_own_d, i_done, d_done;
  mbus_req_t   m_req;
  logic [63:0] m_rdata;
  int          m_streak;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_own_d = 0; m_req = '0; m_rdata = '0; m_streak = 0;
  endtask

  task automatic model_step();
    if (!resetn) model_reset();
    else if (m_resp) m_resp = 0;
    else if (m_busy) begin
      if (bus.mresp.ready) begin
        m_rdata = bus.mresp.data; m_busy = 0; m_resp = 1;
      end
    end else if (bus.dreq.valid && (!bus.ireq.valid || m_streak < MAXS)) begin
      m_req = '{valid: 1'b1, is_write: |bus.dreq.strobe, size: bus.dreq.size,
                addr: bus.dreq.addr, strobe: bus.dreq.strobe, data: bus.dreq.data};
      m_own_d = 1;
      m_streak = !bus.ireq.valid ? 0 : (m_streak + 1 > MAXS ? MAXS : m_streak + 1);
      m_busy = 1;
    end else if (bus.ireq.valid) begin
      m_req = '0;
      m_req.valid = 1'b1;
      m_req.size = MSIZE4;
      m_req.addr = bus.ireq.addr;
      m_own_d = 0;
      m_streak = 0;
      m_busy = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic settle();
    mbus_req_t  em;
    ibus_resp_t ei;
    dbus_resp_t ed;
    #3;
    em = m_busy ? m_req : '0;
    ei = m_resp && !m_own_d && bus.ireq.valid && bus.ireq.addr == m_req.addr
         ? '{addr_ok: 1'b1, data_ok: 1'b1, data: m_rdata} : '0;
    ed = m_resp && m_own_d && bus.dreq.valid && bus.dreq.addr == m_req.addr &&
         bus.dreq.strobe == m_req.strobe
         ? '{addr_ok: 1'b1, data_ok: 1'b1, data: m_rdata} : '0;
    chk("mreq", bus.mreq, em);
    chk("iresp", bus.iresp, ei);
    chk("dresp", bus.dresp, ed);
    i_done = ei.data_ok;
    d_done = ed.data_ok;
  endtask

  task automatic drive_random();
    if (!bus.ireq.valid || i_done) begin
      bus.ireq.valid = $urandom_range(0, 2) != 0;
      bus.ireq.addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    end else if ($urandom_range(0, 15) == 0) begin
      if ($urandom_range(0, 1) == 0) bus.ireq.valid = 1'b0;
      else bus.ireq.addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    end
    if (!bus.dreq.valid || d_done) begin
      bus.dreq.valid  = $urandom_range(0, 2) != 0;
      bus.dreq.addr   = {26'h1, 4'($urandom_range(0, 15)), 2'b00};
      bus.dreq.size   = msize_t'($urandom_range(0, 3));
      bus.dreq.strobe = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'h00;
      bus.dreq.data   = {$urandom, $urandom};
    end else if ($urandom_range(0, 15) == 0) begin
      case ($urandom_range(0, 2))
        0: bus.dreq.valid = 1'b0;
        1: bus.dreq.addr = {26'h1, 4'($urandom_range(0, 15)), 2'b00};
        default: bus.dreq.strobe = bus.dreq.strobe ^ 8'h01;
      endcase
    end
    bus.mresp.ready = $urandom_range(0, 2) != 0;
    bus.mresp.data  = {$urandom, $urandom};
  endtask

  initial begin
    int g;
    bus.ireq = '0; bus.dreq = '0; bus.mresp = '0;
    model_reset();
    tick(); tick();
    resetn = 1'b1;
    settle();
    chk("rst_mreq", bus.mreq, '0);
    chk("rst_iresp", bus.iresp, '0);
    chk("rst_dresp", bus.dresp, '0);
    tick();
    // lone fetch
    bus.ireq = '{valid: 1'b1, addr: 32'h8000_0000};
    settle(); chk("fetch_c0_valid", bus.mreq.valid, 1'b0); tick();
    bus.mresp = '{ready: 1'b1, data: 64'h13};
    settle();
    chk("fetch_c1_valid", bus.mreq.valid, 1'b1);
    chk("fetch_c1_addr", bus.mreq.addr, 32'h8000_0000);
    chk("fetch_c1_size", bus.mreq.size, MSIZE4);
    tick();
    bus.mresp = '0;
    settle();
    chk("fetch_c2_data_ok", bus.iresp.data_ok, 1'b1);
    chk("fetch_c2_data", bus.iresp.data, 64'h13);
    chk("fetch_c2_dresp", bus.dresp, '0);
    tick();
    bus.ireq = '0; settle(); tick();
    // contention: dbus write wins, fetch follows at cycle 3
    bus.ireq = '{valid: 1'b1, addr: 32'h8000_0040};
    bus.dreq = '{valid: 1'b1, addr: 32'h8000_1000, size: MSIZE8, strobe: 8'hFF, data: 64'hDEAD_BEEF};
    settle(); tick();
    bus.mresp = '{ready: 1'b1, data: 64'h0};
    settle();
    chk("cont_is_write", bus.mreq.is_write, 1'b1);
    chk("cont_daddr", bus.mreq.addr, 32'h8000_1000);
    chk("cont_wdata", bus.mreq.data, 64'hDEAD_BEEF);
    tick();
    bus.mresp = '0;
    settle(); chk("cont_d_ok", bus.dresp.data_ok, 1'b1); chk("cont_i_idle", bus.iresp.data_ok, 1'b0); tick();
    bus.dreq = '0;
    settle(); chk("cont_c3_valid", bus.mreq.valid, 1'b0); tick();
    bus.mresp = '{ready: 1'b1, data: 64'h77};
    settle(); chk("cont_iaddr", bus.mreq.addr, 32'h8000_0040); chk("cont_i_read", bus.mreq.is_write, 1'b0); tick();
    bus.mresp = '0;
    settle(); chk("cont_i_ok", bus.iresp.data_ok, 1'b1); tick();
    bus.ireq = '0; settle(); tick();
    // starvation bound: D,D,D,D,I repeating
    bus.ireq  = '{valid: 1'b1, addr: 32'h1000};
    bus.dreq  = '{valid: 1'b1, addr: 32'h2000, size: MSIZE4, strobe: 8'h00, data: 64'h0};
    bus.mresp = '{ready: 1'b1, data: 64'h55};
    g = 0;
    for (int k = 0; k < 30; k++) begin
      settle();
      if (bus.mreq.valid) begin
        chk("starve_grant", bus.mreq.addr, (g % 5 == 4) ? 32'h1000 : 32'h2000);
        g++;
      end
      tick();
    end
    chk("starve_count", 32'(g), 32'd10);
    bus.ireq = '0; bus.dreq = '0; bus.mresp = '0;
    settle(); tick();
    // flush discard then refetch of the new address
    bus.ireq = '{valid: 1'b1, addr: 32'h100};
    settle(); tick();
    bus.ireq.addr = 32'h200;
    settle(); chk("flush_hold1", bus.mreq.addr, 32'h100); tick();
    bus.mresp = '{ready: 1'b1, data: 64'h99};
    settle(); chk("flush_hold2", bus.mreq.addr, 32'h100); tick();
    bus.mresp = '0;
    settle(); chk("flush_discard", bus.iresp.data_ok, 1'b0); tick();
    settle(); tick();
    bus.mresp = '{ready: 1'b1, data: 64'h88};
    settle(); chk("flush_refetch", bus.mreq.addr, 32'h200); tick();
    bus.mresp = '0;
    settle(); chk("flush_ok", bus.iresp.data_ok, 1'b1); tick();
    bus.ireq = '0; settle(); tick();
    // downstream wait of 5 cycles
    bus.dreq = '{valid: 1'b1, addr: 32'h3000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    settle(); tick();
    for (int w = 0; w < 6; w++) begin
      bus.mresp = w == 5 ? '{ready: 1'b1, data: 64'hABC} : '0;
      settle();
      chk("wait_valid", bus.mreq.valid, 1'b1);
      chk("wait_addr", bus.mreq.addr, 32'h3000);
      tick();
    end
    bus.mresp = '0;
    settle(); chk("wait_ok", bus.dresp.data_ok, 1'b1); chk("wait_data", bus.dresp.data, 64'hABC); tick();
    bus.dreq = '0; settle(); tick();
    // asynchronous reset in the middle of a dbus beat
    bus.dreq = '{valid: 1'b1, addr: 32'h4000, size: MSIZE4, strobe: 8'h0F, data: 64'h1234};
    settle(); tick();
    settle();
    chk("areset_pre_valid", bus.mreq.valid, 1'b1);
    #1 resetn = 1'b0;
    model_reset();
    #1;
    chk("areset_mreq", bus.mreq, '0);
    chk("areset_dresp", bus.dresp, '0);
    tick();
    resetn = 1'b1;
    bus.dreq = '0;
    for (int k = 0; k < 4; k++) begin
      settle(); chk("areset_no_ok", bus.dresp.data_ok, 1'b0); tick();
    end
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      settle();
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
